// File: rtl/fft_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// fft_buffer_ctrl
//
// Owns the single-port sample RAM in front of the FFT core for one frame at a
// time. A frame of N = 2**addr_width samples is taken from the input stream and
// written to RAM in natural order. Each write is an accept cycle followed by a
// one-cycle strobe. The frame is then read back onto the output stream in
// natural or bit-reversed address order.
//
// Parameters
//   data_width      sample / RAM word width
//   addr_width      RAM address width, frame length N = 2**addr_width
//
// Ports
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   start           begin a frame (sampled only while idle)
//   reverse_en      bit-reversed readout, latched with start
//   in_valid        input stream valid
//   in_data         input stream sample
//   in_ready        input stream ready
//   out_valid       output stream valid
//   out_data        output stream sample
//   out_ready       output stream ready
//   busy            a frame is in progress
//   frame_done      one-cycle pulse on the first idle cycle after a frame
//   ram_read_write  RAM strobe, rising edge writes, low reads
//   ram_address     RAM address
//   ram_in_data     RAM write data
//   ram_out_data    RAM read data (combinational from ram_address)
// -----------------------------------------------------------------------------
module fft_buffer_ctrl #(
   parameter int unsigned data_width = 16,
   parameter int unsigned addr_width = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  reverse_en,
   input  logic                  in_valid,
   input  logic [data_width-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [data_width-1:0] out_data,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  ram_read_write,
   output logic [addr_width-1:0] ram_address,
   output logic [data_width-1:0] ram_in_data,
   input  logic [data_width-1:0] ram_out_data
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WAIT,
      LOAD_STROBE,
      UNLOAD,
      DRAIN
   } state_t;

   localparam logic [addr_width-1:0] LAST_IDX = '1;

   state_t                state;
   state_t                state_nx;
   logic [addr_width-1:0] wr_idx;
   logic [addr_width-1:0] rd_idx;
   logic [addr_width-1:0] rd_idx_inc;
   logic                  rev_q;
   logic                  take_out;

   // Readout address for sample index idx: identity, or idx with its bits
   // mirrored when the frame was started with reverse_en.
   function automatic logic [addr_width-1:0] map_addr(
      input logic [addr_width-1:0] idx,
      input logic                  rev
   );
      logic [addr_width-1:0] r;
      r = idx;
      if (rev) begin
         r = {<<{idx}};
      end
      return r;
   endfunction

   assign rd_idx_inc = rd_idx + 1'b1;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and state-decoded outputs. in_ready, busy and the strobe come
   // straight from the state so that an asynchronous reset clears them at once.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx       = state;
      in_ready       = 1'b0;
      ram_read_write = 1'b0;
      busy           = 1'b1;
      take_out       = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nx = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = LOAD_STROBE;
            end
         end
         LOAD_STROBE: begin
            ram_read_write = 1'b1;
            if (wr_idx == LAST_IDX) begin
               state_nx = UNLOAD;
            end else begin
               state_nx = LOAD_WAIT;
            end
         end
         UNLOAD: begin
            // The output register may be refilled when empty or being consumed.
            take_out = !out_valid || out_ready;
            if (take_out && (rd_idx == LAST_IDX)) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: counters, RAM address/data registers and the output register.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_idx      <= '0;
         rd_idx      <= '0;
         rev_q       <= 1'b0;
         ram_address <= '0;
         ram_in_data <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rev_q  <= reverse_en;
                  wr_idx <= '0;
               end
            end
            LOAD_WAIT: begin
               // Address and data are registered here so they are already
               // settled when the strobe rises on the following cycle.
               if (in_valid) begin
                  ram_in_data <= in_data;
                  ram_address <= wr_idx;
               end
            end
            LOAD_STROBE: begin
               if (wr_idx == LAST_IDX) begin
                  rd_idx      <= '0;
                  ram_address <= map_addr('0, rev_q);
               end else begin
                  wr_idx <= wr_idx + 1'b1;
               end
            end
            UNLOAD: begin
               if (take_out) begin
                  out_data  <= ram_out_data;
                  out_valid <= 1'b1;
                  // After the last capture the index and address are left in
                  // place rather than wrapping back to the start of the frame.
                  if (rd_idx != LAST_IDX) begin
                     rd_idx      <= rd_idx_inc;
                     ram_address <= map_addr(rd_idx_inc, rev_q);
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_buffer_ctrl.sv
module tb_fft_buffer_ctrl;

   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int N     = 1 << AW;
   localparam int LIMIT = 400;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          reverse_en = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          frame_done;
   logic          ram_read_write;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_in_data;
   logic [DW-1:0] ram_out_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fft_buffer_ctrl #(
      .data_width(DW),
      .addr_width(AW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .reverse_en    (reverse_en),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .busy          (busy),
      .frame_done    (frame_done),
      .ram_read_write(ram_read_write),
      .ram_address   (ram_address),
      .ram_in_data   (ram_in_data),
      .ram_out_data  (ram_out_data)
   );

   // Behavioural single-port RAM. Address and data are stable for the whole
   // strobe cycle, so committing mid-strobe equals committing on its edge.
   logic [DW-1:0] mem [N];
   assign ram_out_data = mem[ram_address];
   always @(negedge clk) begin
      if (ram_read_write) mem[ram_address] <= ram_in_data;
   end

   int strobe_edges = 0;
   always @(posedge ram_read_write) strobe_edges <= strobe_edges + 1;

   // Reference frame and observations of the last frame
   logic [DW-1:0] smp [N];
   logic [DW-1:0] obs_out[$];
   logic [AW-1:0] wr_addr_q[$];
   logic [DW-1:0] wr_data_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int unsigned   done_cnt, overlap, hold_n, hold_bad, edge0;
   int unsigned   t_done, t_first_valid, t_last_strobe, t_last_take;
   logic          busy1, ready1, chain_busy;
   bit            timed_out;

   function automatic int unsigned bitrev(input int unsigned i);
      int unsigned r;
      r = 0;
      for (int b = 0; b < AW; b++) r = r * 2 + ((i >> b) & 1);
      return r;
   endfunction

   function automatic logic [DW-1:0] exp_out(input int unsigned i, input bit rev);
      return rev ? smp[bitrev(i)] : smp[i];
   endfunction

   // Drives one frame from start to frame_done and records what is seen.
   task automatic run_frame(input bit rev, input int unsigned vpct, input int unsigned rpct,
                            input int bp_at, input bit noise, input bit chain);
      int unsigned   cyc, sent;
      bit            stop, bp_done;
      logic [DW-1:0] snap_d;
      logic [AW-1:0] snap_a;
      obs_out.delete(); wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      done_cnt = 0; overlap = 0; hold_n = 0; hold_bad = 0;
      t_done = 0; t_first_valid = 0; t_last_strobe = 0; t_last_take = 0;
      busy1 = 0; ready1 = 0; chain_busy = 0; edge0 = strobe_edges;
      cyc = 0; sent = 0; stop = 0; bp_done = 0; snap_d = '0; snap_a = '0;
      @(negedge clk);
      start = 1; reverse_en = rev; in_valid = 0; out_ready = 0;
      while (!stop && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin busy1 = busy; ready1 = in_ready; end
         if (frame_done) begin done_cnt++; if (t_done == 0) t_done = cyc; end
         if (in_ready && ram_read_write) overlap++;
         if (ram_read_write) begin
            wr_addr_q.push_back(ram_address);
            wr_data_q.push_back(ram_in_data);
            t_last_strobe = cyc;
         end else if (busy && wr_data_q.size() == N &&
                      (rd_addr_q.size() == 0 || rd_addr_q[$] !== ram_address)) begin
            rd_addr_q.push_back(ram_address);
         end
         if (out_valid && t_first_valid == 0) t_first_valid = cyc;
         if (noise && done_cnt == 0) begin
            start = 1'($urandom_range(0, 1));
            reverse_en = 1'($urandom_range(0, 1));
         end else begin
            start = 0;
         end
         if (sent < N && $urandom_range(0, 99) < vpct) begin
            in_valid = 1; in_data = smp[sent];
         end else begin
            in_valid = 0; in_data = DW'($urandom);
         end
         if (in_valid && in_ready) sent++;
         if (bp_at >= 0 && !bp_done && out_valid && obs_out.size() == bp_at) begin
            if (hold_n == 0) begin snap_d = out_data; snap_a = ram_address; end
            else if (out_data !== snap_d || ram_address !== snap_a) hold_bad++;
            hold_n++;
            out_ready = 0;
            if (hold_n == 5) bp_done = 1;
         end else begin
            out_ready = ($urandom_range(0, 99) < rpct);
         end
         if (out_valid && out_ready) begin obs_out.push_back(out_data); t_last_take = cyc; end
         if (done_cnt > 0) begin
            if (chain) begin
               if (cyc == t_done) start = 1;
               else begin chain_busy = busy; start = 0; stop = 1; end
            end else if (cyc >= t_done + 3) begin
               stop = 1;
            end
         end
      end
      in_valid = 0; out_ready = 0; start = 0;
      timed_out = (done_cnt == 0);
   endtask

   task automatic test_reset();
      int unsigned strobes, busy_hi;
      bit hit;
      reset_n = 0; start = 0; in_valid = 0; out_ready = 0;
      repeat (3) @(negedge clk);
      total++; if ({in_ready, out_valid, busy, frame_done, ram_read_write} !== 5'b0) begin
         bad++; $display("FAIL rst_ctrl: got %b want 00000", {in_ready, out_valid, busy, frame_done, ram_read_write}); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      total++; if (ram_address !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", ram_address); end
      total++; if (ram_in_data !== '0) begin bad++; $display("FAIL rst_in_data: got %h want 0", ram_in_data); end
      reset_n = 1;
      @(negedge clk);
      start = 1; reverse_en = 0;
      strobes = 0; hit = 0;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk);
         start = 0; in_valid = 1; in_data = DW'($urandom);
         if (ram_read_write) begin strobes++; if (strobes == 3) hit = 1; end
      end
      total++; if (!hit) begin bad++; $display("FAIL rst_reach_strobe: got %0d strobes want 3", strobes); end
      #2 reset_n = 0;
      #1;
      total++; if ({in_ready, out_valid, busy, frame_done, ram_read_write} !== 5'b0) begin
         bad++; $display("FAIL arst_ctrl: got %b want 00000", {in_ready, out_valid, busy, frame_done, ram_read_write}); end
      total++; if (ram_address !== '0) begin bad++; $display("FAIL arst_addr: got %h want 0", ram_address); end
      total++; if (ram_in_data !== '0) begin bad++; $display("FAIL arst_in_data: got %h want 0", ram_in_data); end
      in_valid = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      busy_hi = 0;
      repeat (3) begin @(negedge clk); if (busy) busy_hi++; end
      total++; if (busy_hi != 0) begin bad++; $display("FAIL rst_busy_after: got %0d busy cycles want 0", busy_hi); end
      for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
      run_frame(0, 100, 100, -1, 0, 0);
      total++; if (timed_out) begin bad++; $display("FAIL rst_frame_timeout: got no frame_done want 1"); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 0)) begin
            bad++; $display("FAIL rst_frame_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 0)); end
      end
   endtask

   task automatic test_natural();
      for (int i = 0; i < N; i++) smp[i] = DW'(16'h10 + i);
      run_frame(0, 100, 100, -1, 0, 0);
      total++; if (timed_out) begin bad++; $display("FAIL nat_timeout: got no frame_done want 1"); end
      total++; if ({busy1, ready1} !== 2'b11) begin bad++; $display("FAIL nat_start: got busy/ready %b want 11", {busy1, ready1}); end
      total++; if (wr_addr_q.size() != N) begin bad++; $display("FAIL nat_strobes: got %0d want %0d", wr_addr_q.size(), N); end
      total++; if (strobe_edges - edge0 != N) begin bad++; $display("FAIL nat_strobe_edges: got %0d want %0d", strobe_edges - edge0, N); end
      for (int i = 0; i < N; i++) begin
         total++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== smp[i]) begin
            bad++; $display("FAIL nat_write[%0d]: got %h@%0d want %h@%0d", i, wr_data_q[i], wr_addr_q[i], smp[i], i); end
      end
      total++; if (obs_out.size() != N) begin bad++; $display("FAIL nat_count: got %0d want %0d", obs_out.size(), N); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 0)) begin
            bad++; $display("FAIL nat_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 0)); end
      end
      total++; if (t_first_valid - t_last_strobe != 2) begin
         bad++; $display("FAIL nat_first_valid_lat: got %0d want 2", t_first_valid - t_last_strobe); end
      total++; if (t_last_take - t_first_valid != N - 1) begin
         bad++; $display("FAIL nat_readout_rate: got %0d want %0d", t_last_take - t_first_valid, N - 1); end
      total++; if (t_done - t_last_take != 1) begin bad++; $display("FAIL nat_done_lat: got %0d want 1", t_done - t_last_take); end
      total++; if (t_done != 3 * N + 2) begin bad++; $display("FAIL nat_frame_time: got %0d want %0d", t_done, 3 * N + 2); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL nat_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reverse();
      for (int i = 0; i < N; i++) smp[i] = DW'(16'h10 + i);
      run_frame(1, 100, 100, -1, 0, 0);
      total++; if (timed_out) begin bad++; $display("FAIL rev_timeout: got no frame_done want 1"); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 1)) begin
            bad++; $display("FAIL rev_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 1)); end
      end
      total++; if (rd_addr_q.size() != N) begin bad++; $display("FAIL rev_addr_count: got %0d want %0d", rd_addr_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         total++; if (rd_addr_q[i] !== AW'(bitrev(i))) begin
            bad++; $display("FAIL rev_addr[%0d]: got %0d want %0d", i, rd_addr_q[i], bitrev(i)); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rev_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_input_gaps();
      bit rev;
      for (int f = 0; f < 3; f++) begin
         rev = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
         run_frame(rev, 40, 70, -1, 0, 0);
         total++; if (timed_out) begin bad++; $display("FAIL gap_timeout: got no frame_done want 1"); end
         total++; if (overlap != 0) begin bad++; $display("FAIL gap_ready_in_strobe: got %0d want 0", overlap); end
         total++; if (wr_data_q.size() != N || strobe_edges - edge0 != N) begin
            bad++; $display("FAIL gap_write_count: got %0d/%0d want %0d", wr_data_q.size(), strobe_edges - edge0, N); end
         for (int i = 0; i < N; i++) begin
            total++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== smp[i]) begin
               bad++; $display("FAIL gap_write[%0d]: got %h@%0d want %h@%0d", i, wr_data_q[i], wr_addr_q[i], smp[i], i); end
            total++; if (obs_out[i] !== exp_out(i, rev)) begin
               bad++; $display("FAIL gap_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, rev)); end
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
      run_frame(0, 100, 100, 3, 0, 0);
      total++; if (timed_out) begin bad++; $display("FAIL bp_timeout: got no frame_done want 1"); end
      total++; if (hold_n != 5) begin bad++; $display("FAIL bp_hold_cycles: got %0d want 5", hold_n); end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_held_values: got %0d changes want 0", hold_bad); end
      total++; if (obs_out.size() != N) begin bad++; $display("FAIL bp_count: got %0d want %0d", obs_out.size(), N); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 0)) begin
            bad++; $display("FAIL bp_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 0)); end
      end
   endtask

   task automatic test_ignored_controls();
      int unsigned busy_hi;
      for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
      run_frame(0, 80, 80, -1, 1, 0);
      total++; if (timed_out) begin bad++; $display("FAIL ign_timeout: got no frame_done want 1"); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
      for (int i = 0; i < N; i++) begin
         total++; if (wr_addr_q[i] !== AW'(i)) begin
            bad++; $display("FAIL ign_write_addr[%0d]: got %0d want %0d", i, wr_addr_q[i], i); end
         total++; if (obs_out[i] !== exp_out(i, 0)) begin
            bad++; $display("FAIL ign_out[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 0)); end
      end
      busy_hi = 0;
      repeat (3) begin @(negedge clk); if (busy) busy_hi++; end
      total++; if (busy_hi != 0) begin bad++; $display("FAIL ign_idle_after: got %0d busy cycles want 0", busy_hi); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
      run_frame(1, 100, 100, -1, 0, 1);
      total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout1: got no frame_done want 1"); end
      total++; if (chain_busy !== 1'b1) begin bad++; $display("FAIL b2b_restart: got busy %b want 1", chain_busy); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 1)) begin
            bad++; $display("FAIL b2b_out1[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 1)); end
      end
      for (int i = 0; i < N; i++) smp[i] = DW'($urandom);
      run_frame(1, 100, 100, -1, 0, 0);
      total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout2: got no frame_done want 1"); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
      for (int i = 0; i < N; i++) begin
         total++; if (obs_out[i] !== exp_out(i, 1)) begin
            bad++; $display("FAIL b2b_out2[%0d]: got %h want %h", i, obs_out[i], exp_out(i, 1)); end
      end
   endtask

   initial begin
      test_reset();
      test_natural();
      test_reverse();
      test_input_gaps();
      test_backpressure();
      test_ignored_controls();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
